// File: rtl/window_pkg.sv
// Shared constants and helpers for the 5x5 sliding-window generator.
package window_pkg;

  localparam int WIN_DIM       = 5;
  localparam int WIN_ELEMS     = WIN_DIM * WIN_DIM;
  localparam int NUM_LINE_BUFS = WIN_DIM - 1;
  localparam int DEFAULT_DSIZE = 8;

  // Flat element index of window position (r, c); r=0 is the oldest line.
  function automatic int elem_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

endpackage

// File: rtl/win_line_buf.sv
// One line of pixel delay: read-before-write memory addressed by the column.
module win_line_buf
  import window_pkg::*;
#(
  parameter int DSIZE = DEFAULT_DSIZE,
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     i_en,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DSIZE-1:0]         i_wr_data,
  output logic [DSIZE-1:0]         o_rd_data
);

  logic [DSIZE-1:0] r_mem [DEPTH];

  // Old contents at the address are visible combinationally, so the read
  // returns the pixel written one line earlier before this edge overwrites it.
  assign o_rd_data = r_mem[i_addr];

  // Store the incoming pixel on every accepted cycle.
  // NOTE: the memory has no reset; stale lines are harmless because the
  // window is only flagged valid once four fresh lines have been written.
  always_ff @(posedge clock) begin
    if (i_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/window_5x5_gen.sv
// 5x5 sliding-window generator: four cascaded line buffers feed a 5x5
// shift register; a window is flagged once the pixel position is >= (4,4).
module window_5x5_gen
  import window_pkg::*;
#(
  parameter int DSIZE = DEFAULT_DSIZE,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [DSIZE-1:0]             in_data,
  output logic                         out_valid,
  output logic [WIN_ELEMS*DSIZE-1:0]   win,
  output logic                         out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN_DIM - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col_next;
  logic [ROW_W-1:0] w_row_next;
  logic             w_accept;

  logic [DSIZE-1:0] w_lb_wr  [NUM_LINE_BUFS];
  logic [DSIZE-1:0] w_lb_rd  [NUM_LINE_BUFS];
  logic [DSIZE-1:0] w_new_col[WIN_DIM];
  logic [DSIZE-1:0] r_win    [WIN_DIM][WIN_DIM];

  logic r_out_valid;
  logic r_out_last;

  // Line buffers must not advance while reset is asserted.
  assign w_accept = in_valid & ~reset;

  // Position of the current pixel: start-of-frame forces (0,0); also the
  // position the counters advance to for the following pixel.
  // NOTE: every combinational output gets a value on all paths, so no latch.
  always_comb begin
    w_col      = in_sof ? '0 : r_col;
    w_row      = in_sof ? '0 : r_row;
    w_col_next = w_col + 1'b1;
    w_row_next = w_row;
    if (w_col == COL_LAST) begin
      w_col_next = '0;
      w_row_next = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
    end
  end

  // Cascade wiring and the new right-hand column (top row = oldest line).
  always_comb begin
    w_lb_wr[0] = in_data;
    for (int i = 1; i < NUM_LINE_BUFS; i++) begin
      w_lb_wr[i] = w_lb_rd[i-1];
    end
    for (int r = 0; r < NUM_LINE_BUFS; r++) begin
      w_new_col[r] = w_lb_rd[NUM_LINE_BUFS-1-r];
    end
    w_new_col[WIN_DIM-1] = in_data;
  end

  for (genvar g = 0; g < NUM_LINE_BUFS; g++) begin : g_lb
    win_line_buf #(
      .DSIZE(DSIZE),
      .DEPTH(IMG_W)
    ) u_lb (
      .clock    (clock),
      .i_en     (w_accept),
      .i_addr   (w_col),
      .i_wr_data(w_lb_wr[g]),
      .o_rd_data(w_lb_rd[g])
    );
  end

  // Counters, window shift and output flags, all advanced per accepted pixel.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (in_valid) begin
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_out_valid <= (w_row >= ROW_MIN) && (w_col >= COL_MIN);
      r_out_last  <= (w_row == ROW_LAST) && (w_col == COL_LAST);
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][WIN_DIM-1] <= w_new_col[r];
      end
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Flatten the window: element k = 5r+c at win[k*DSIZE +: DSIZE].
  always_comb begin
    win = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        win[elem_idx(r, c)*DSIZE +: DSIZE] = r_win[r][c];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed bench for window_5x5_gen on an 8x8 image; pixel value at (R,C)
// is base + 8*R + C so every expected window element is computed directly.
module tb_window_5x5_gen;

  localparam int DSIZE = 8;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int WB    = 25 * DSIZE;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_sof;
  logic [DSIZE-1:0] in_data;
  logic             out_valid;
  logic [WB-1:0]    win;
  logic             out_last;

  int checks = 0;
  int errors = 0;

  window_5x5_gen #(
    .DSIZE(DSIZE),
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .out_valid(out_valid),
    .win      (win),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  function automatic logic [DSIZE-1:0] pix(input int r, input int c, input int base);
    return DSIZE'(base + 8 * r + c);
  endfunction

  // Expected window for the pixel at (R,C): element (r,c) = pixel (R-4+r, C-4+c).
  function automatic logic [WB-1:0] exp_win(input int rr, input int cc, input int base);
    logic [WB-1:0] v;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        v[(5*r+c)*DSIZE +: DSIZE] = pix(rr - 4 + r, cc - 4 + c, base);
    return v;
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic s, input logic [DSIZE-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 8'hA5);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out_last got %b want 0", out_last);
    end
    checks++;
    if (win !== '0) begin
      errors++; $display("FAIL reset_win got %h want 0", win);
    end
    reset = 1'b0;
  endtask

  task automatic test_gapless;
    int nwin = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic ev, el;
        step(1'b1, (r == 0 && c == 0), pix(r, c, 0));
        ev = (r >= 4 && c >= 4);
        el = (r == H-1 && c == W-1);
        checks++;
        if (out_valid !== ev) begin
          errors++; $display("FAIL gapless_valid (%0d,%0d) got %b want %b", r, c, out_valid, ev);
        end
        checks++;
        if (out_last !== el) begin
          errors++; $display("FAIL gapless_last (%0d,%0d) got %b want %b", r, c, out_last, el);
        end
        if (ev) begin
          nwin++;
          checks++;
          if (win !== exp_win(r, c, 0)) begin
            errors++; $display("FAIL gapless_win (%0d,%0d) got %h want %h", r, c, win, exp_win(r, c, 0));
          end
        end
        if (r == 4 && c == 4) begin
          checks++;
          if ({win[0*8 +: 8], win[4*8 +: 8], win[12*8 +: 8], win[24*8 +: 8]} !== {8'd0, 8'd4, 8'd18, 8'd36}) begin
            errors++; $display("FAIL first_win_elems got %0d/%0d/%0d/%0d want 0/4/18/36",
                               win[0*8 +: 8], win[4*8 +: 8], win[12*8 +: 8], win[24*8 +: 8]);
          end
        end
        if (r == 7 && c == 7) begin
          checks++;
          if (win[7:0] !== 8'd27) begin
            errors++; $display("FAIL last_win_elem0 got %0d want 27", win[7:0]);
          end
        end
      end
    end
    checks++;
    if (nwin != 16) begin
      errors++; $display("FAIL gapless_count got %0d want 16", nwin);
    end
  endtask

  task automatic test_gapped;
    int nwin = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int idle;
        logic ev;
        idle = ($urandom_range(1, 0) == 1) ? int'($urandom_range(3, 1)) : 0;
        for (int k = 0; k < idle; k++) begin
          // in_sof high while idle must be ignored
          step(1'b0, 1'b1, 8'hEE);
          checks++;
          if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("FAIL gapped_idle (%0d,%0d) got valid=%b last=%b want 0/0", r, c, out_valid, out_last);
          end
        end
        step(1'b1, (r == 0 && c == 0), pix(r, c, 0));
        ev = (r >= 4 && c >= 4);
        checks++;
        if (out_valid !== ev || out_last !== (r == H-1 && c == W-1)) begin
          errors++; $display("FAIL gapped_flags (%0d,%0d) got valid=%b last=%b want valid=%b", r, c, out_valid, out_last, ev);
        end
        if (ev) begin
          nwin++;
          checks++;
          if (win !== exp_win(r, c, 0)) begin
            errors++; $display("FAIL gapped_win (%0d,%0d) got %h want %h", r, c, win, exp_win(r, c, 0));
          end
        end
      end
    end
    checks++;
    if (nwin != 16) begin
      errors++; $display("FAIL gapped_count got %0d want 16", nwin);
    end
  endtask

  task automatic test_midframe_restart;
    int nwin = 0;
    // old frame, pixels 0..19
    for (int p = 0; p < 20; p++) begin
      step(1'b1, (p == 0), pix(p / W, p % W, 0));
    end
    // new frame starts at pixel 20 with in_sof
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic ev;
        step(1'b1, (r == 0 && c == 0), pix(r, c, 100));
        ev = (r >= 4 && c >= 4);
        checks++;
        if (out_valid !== ev) begin
          errors++; $display("FAIL restart_valid (%0d,%0d) got %b want %b", r, c, out_valid, ev);
        end
        if (ev) begin
          nwin++;
          checks++;
          if (win !== exp_win(r, c, 100)) begin
            errors++; $display("FAIL restart_win (%0d,%0d) got %h want %h", r, c, win, exp_win(r, c, 100));
          end
        end
      end
    end
    checks++;
    if (nwin != 16 || out_last !== 1'b1) begin
      errors++; $display("FAIL restart_count got %0d last=%b want 16 last=1", nwin, out_last);
    end
  endtask

  task automatic test_reset_midframe;
    int nwin = 0;
    for (int p = 0; p < 30; p++) begin
      step(1'b1, (p == 0), pix(p / W, p % W, 0));
    end
    // reset wins over the pixel offered in the same cycle
    reset = 1'b1;
    step(1'b1, 1'b0, pix(3, 6, 0));
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || win !== '0) begin
      errors++; $display("FAIL midreset got valid=%b win=%h want 0/0", out_valid, win);
    end
    // no in_sof: first pixel after reset is (0,0)
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic ev;
        step(1'b1, 1'b0, pix(r, c, 0));
        ev = (r >= 4 && c >= 4);
        checks++;
        if (out_valid !== ev || out_last !== (r == H-1 && c == W-1)) begin
          errors++; $display("FAIL midreset_flags (%0d,%0d) got valid=%b last=%b want valid=%b", r, c, out_valid, out_last, ev);
        end
        if (ev) begin
          nwin++;
          checks++;
          if (win !== exp_win(r, c, 0)) begin
            errors++; $display("FAIL midreset_win (%0d,%0d) got %h want %h", r, c, win, exp_win(r, c, 0));
          end
        end
      end
    end
    checks++;
    if (nwin != 16) begin
      errors++; $display("FAIL midreset_count got %0d want 16", nwin);
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 2; f++) begin
      int nwin  = 0;
      int nlast = 0;
      int base  = 64 * f;
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          logic ev;
          // only the first frame carries in_sof; the second relies on wrap
          step(1'b1, (f == 0 && r == 0 && c == 0), pix(r, c, base));
          ev = (r >= 4 && c >= 4);
          checks++;
          if (out_valid !== ev) begin
            errors++; $display("FAIL b2b_valid f%0d (%0d,%0d) got %b want %b", f, r, c, out_valid, ev);
          end
          if (out_last === 1'b1) nlast++;
          if (ev) begin
            nwin++;
            checks++;
            if (win !== exp_win(r, c, base)) begin
              errors++; $display("FAIL b2b_win f%0d (%0d,%0d) got %h want %h", f, r, c, win, exp_win(r, c, base));
            end
          end
        end
      end
      checks++;
      if (nwin != 16 || nlast != 1) begin
        errors++; $display("FAIL b2b_count f%0d got %0d windows %0d lasts want 16/1", f, nwin, nlast);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    test_reset;
    test_gapless;
    test_gapped;
    test_midframe_restart;
    test_reset_midframe;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_5x5_gen.md
WINDOW_5X5_GEN -- requirements
Module: window_5x5_gen

Interface
REQ-001 Parameter DSIZE, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 32, pixels per line; legal range 5..1024.
REQ-003 Parameter IMG_H, default 32, lines per frame; legal range 5..1024.
REQ-004 clock  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  pixel accepted on every clock edge where it is high; no backpressure.
REQ-007 in_sof  input  1  start of frame; meaningful only while in_valid is high.
REQ-008 in_data  input  DSIZE  pixel value, raster order.
REQ-009 out_valid  output  1  win holds a complete 5x5 window.
REQ-010 win  output  25*DSIZE  window; element k=5r+c at win[k*DSIZE +: DSIZE]; elements map in order to id00..id24 of the downstream 25-input sorter.
REQ-011 out_last  output  1  high with the final window of a frame.

Function
REQ-012 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) that advance only on accepted pixels.
REQ-013 An accepted pixel with in_sof high SHALL be treated as row 0, col 0, regardless of the counter state; the counters then advance from there.
REQ-014 When col = IMG_W-1, the next accepted pixel SHALL have col 0 and row+1; after (IMG_H-1, IMG_W-1) the counters SHALL wrap to (0,0).
REQ-015 The block SHALL hold four line buffers, each of depth IMG_W, cascaded at a shared address col: read before write, lb0[col]<=in_data, lbN[col]<=lbN-1[col].
REQ-016 On each accepted pixel, the 5x5 window register SHALL shift one column left; the new column c=4 SHALL be r0=lb3[col], r1=lb2[col], r2=lb1[col], r3=lb0[col], r4=in_data.
REQ-017 Element (r,c) SHALL equal the pixel at image position (row-4+r, col-4+c) of the pixel that produced the window; r=0 is the oldest line and c=0 is the leftmost column.
REQ-018 out_valid SHALL go high exactly one cycle after an accepted pixel with row>=4 and col>=4; otherwise it SHALL be low, including every cycle that follows an in_valid-low cycle.
REQ-019 Latency SHALL be 1 clock from the accepted pixel to its window.
REQ-020 out_last SHALL be high only together with out_valid, for the window produced by the pixel at (IMG_H-1, IMG_W-1).
REQ-021 Borders SHALL NOT be padded; each frame SHALL yield exactly (IMG_W-4)*(IMG_H-4) windows.
REQ-022 win SHALL hold its last value while out_valid is low; downstream SHALL NOT use win in those cycles.
REQ-023 in_sof arriving mid-frame SHALL abandon the current frame; stale line-buffer data SHALL NOT reach a valid window, because of the row>=4 gating.
REQ-024 While in_valid is low, in_sof SHALL be ignored and no state SHALL change.

Reset
REQ-025 While reset is high, col, row, out_valid, out_last and win SHALL be 0 on the next edge.
REQ-026 Line-buffer contents SHALL NOT be reset.
REQ-027 The first accepted pixel after reset SHALL be treated as (0,0), with or without in_sof.
REQ-028 reset SHALL take priority over in_valid and in_sof in the same cycle.

Structure
REQ-029 The shared package window_pkg SHALL define WIN_DIM=5, WIN_ELEMS=25, the element index function k=5r+c, and the default DSIZE.
REQ-030 One sub-module, win_line_buf, SHALL implement a single DSIZE x IMG_W read-before-write delay line with an enable input; it is instantiated four times.
REQ-031 The counters, window shift register and output registers SHALL reside in window_5x5_gen.

Verification
REQ-032 Gapless frame -> first valid window: with IMG_W=IMG_H=8 and pixel value 8*row+col, out_valid rises 1 cycle after pixel 36; win elements 0/4/12/24 = 0/4/18/36.
REQ-033 Window count -> the same frame yields exactly 16 windows; out_last is high with the window of pixel 63, whose element 0 = 27.
REQ-034 Gapped input -> in_valid toggled randomly 50% produces window contents identical to the gapless case, and out_valid is never high after a cycle with in_valid low.
REQ-035 Mid-frame restart -> in_sof at pixel 20 restarts the frame; no out_valid until the new (4,4) pixel, and that window contains only new-frame data.
REQ-036 Reset mid-frame -> reset at pixel 30 forces out_valid=0 and win=0; the next pixel is treated as (0,0) and the following frame matches REQ-032.
REQ-037 Back-to-back frames -> two frames without a gap and without in_sof on the second frame wrap correctly, giving 16 windows each.
